// File: rtl/qhy_mac_sequencer_if.sv
// Operand/result handshake bundle for the Q^H*y sequencer.
// master drives operands and out_ready; slave returns in_ready, out_valid and z.
interface qhy_mac_sequencer_if #(
  parameter int W = 28
);
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] y0_re, y0_im, y1_re, y1_im;
  logic signed [W-1:0] q00_re, q00_im, q01_re, q01_im;
  logic signed [W-1:0] q10_re, q10_im, q11_re, q11_im;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] z0_re, z0_im, z1_re, z1_im;

  modport master (
    output in_valid, y0_re, y0_im, y1_re, y1_im,
           q00_re, q00_im, q01_re, q01_im, q10_re, q10_im, q11_re, q11_im,
           out_ready,
    input  in_ready, out_valid, z0_re, z0_im, z1_re, z1_im
  );

  modport slave (
    input  in_valid, y0_re, y0_im, y1_re, y1_im,
           q00_re, q00_im, q01_re, q01_im, q10_re, q10_im, q11_re, q11_im,
           out_ready,
    output in_ready, out_valid, z0_re, z0_im, z1_re, z1_im
  );
endinterface

// File: rtl/qhy_mac_sequencer.sv
// z = Q^H*y via one time-shared conjugate MAC; accept -> out_valid in 5 cycles, 6-cycle period.
// One vector in flight: in_ready only in IDLE; z held stable in OUT until out_ready.
module qhy_mac_sequencer #(
  parameter int W    = 28,
  parameter int FRAC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  qhy_mac_sequencer_if.slave bus,
  output logic              busy
);
  localparam int AW = 2*W + 2;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t              state, state_nxt;
  logic [1:0]          s;
  logic                in_ready_i;
  logic                accept;
  logic                out_valid_q;

  logic signed [W-1:0] y_re [2];
  logic signed [W-1:0] y_im [2];
  logic signed [W-1:0] q_re [2][2];
  logic signed [W-1:0] q_im [2][2];

  logic signed [W-1:0]   qr, qi, yr, yi;
  logic signed [2*W-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [AW-1:0]  prod_re, prod_im;
  logic signed [AW-1:0]  acc_re, acc_im, acc_re_nxt, acc_im_nxt;
  logic signed [W-1:0]   z0_re_q, z0_im_q, z1_re_q, z1_im_q;

  assign in_ready_i    = (state == IDLE);
  assign accept        = bus.in_valid && in_ready_i;
  assign bus.in_ready  = in_ready_i;
  assign bus.out_valid = out_valid_q;
  assign bus.z0_re     = z0_re_q;
  assign bus.z0_im     = z0_im_q;
  assign bus.z1_re     = z1_re_q;
  assign bus.z1_im     = z1_im_q;
  assign busy          = (state != IDLE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.in_valid)   state_nxt = MAC;
      MAC:     if (s == 2'd3)      state_nxt = OUT;
      OUT:     if (bus.out_ready)  state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // Step s selects output index i = s[1] and input index k = s[0]; operand is Q[k][i].
  always_comb begin
    qr   = q_re[s[0]][s[1]];
    qi   = q_im[s[0]][s[1]];
    yr   = y_re[s[0]];
    yi   = y_im[s[0]];
    p_rr = qr * yr;
    p_ii = qi * yi;
    p_ri = qr * yi;
    p_ir = qi * yr;
    prod_re    = AW'(p_rr) + AW'(p_ii);
    prod_im    = AW'(p_ri) - AW'(p_ir);
    acc_re_nxt = s[0] ? (acc_re + prod_re) : prod_re;
    acc_im_nxt = s[0] ? (acc_im + prod_im) : prod_im;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        y_re[k] <= '0;
        y_im[k] <= '0;
        for (int i = 0; i < 2; i++) begin
          q_re[k][i] <= '0;
          q_im[k][i] <= '0;
        end
      end
    end else if (accept) begin
      y_re[0]    <= bus.y0_re;   y_im[0]    <= bus.y0_im;
      y_re[1]    <= bus.y1_re;   y_im[1]    <= bus.y1_im;
      q_re[0][0] <= bus.q00_re;  q_im[0][0] <= bus.q00_im;
      q_re[0][1] <= bus.q01_re;  q_im[0][1] <= bus.q01_im;
      q_re[1][0] <= bus.q10_re;  q_im[1][0] <= bus.q10_im;
      q_re[1][1] <= bus.q11_re;  q_im[1][1] <= bus.q11_im;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      s           <= 2'd0;
      out_valid_q <= 1'b0;
      acc_re      <= '0;
      acc_im      <= '0;
      z0_re_q     <= '0;
      z0_im_q     <= '0;
      z1_re_q     <= '0;
      z1_im_q     <= '0;
    end else begin
      state       <= state_nxt;
      out_valid_q <= (state_nxt == OUT);
      if (accept) begin
        s <= 2'd0;
      end else if (state == MAC) begin
        s      <= s + 2'd1;
        acc_re <= acc_re_nxt;
        acc_im <= acc_im_nxt;
        // Output slice wraps: bits above FRAC+W-1 are dropped, no rounding.
        if (s == 2'd1) begin
          z0_re_q <= acc_re_nxt[FRAC+W-1:FRAC];
          z0_im_q <= acc_im_nxt[FRAC+W-1:FRAC];
        end
        if (s == 2'd3) begin
          z1_re_q <= acc_re_nxt[FRAC+W-1:FRAC];
          z1_im_q <= acc_im_nxt[FRAC+W-1:FRAC];
        end
      end
    end
  end
endmodule

// File: tb/tb_qhy_mac_sequencer.sv
// Directed + random bench for qhy_mac_sequencer with an expected-result queue.
module tb_qhy_mac_sequencer;
  localparam int W = 28;

  typedef logic signed [W-1:0] w_t;
  typedef struct packed {
    w_t y0r, y0i, y1r, y1i;
    w_t q00r, q00i, q01r, q01i, q10r, q10i, q11r, q11i;
  } ops_t;
  typedef struct packed { w_t z0r, z0i, z1r, z1i; } z_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, busy16;
  int   n_checks = 0;
  int   n_fail   = 0;
  z_t   exp_q[$];

  qhy_mac_sequencer_if #(.W(W)) bus ();
  qhy_mac_sequencer_if #(.W(W)) bus16 ();

  qhy_mac_sequencer #(.W(W), .FRAC(0))  dut   (.clk(clk), .rst_n(rst_n), .bus(bus),   .busy(busy));
  qhy_mac_sequencer #(.W(W), .FRAC(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16), .busy(busy16));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint cre(w_t qr, w_t qi, w_t yr, w_t yi);
    return longint'(qr) * longint'(yr) + longint'(qi) * longint'(yi);
  endfunction

  function automatic longint cim(w_t qr, w_t qi, w_t yr, w_t yi);
    return longint'(qr) * longint'(yi) - longint'(qi) * longint'(yr);
  endfunction

  function automatic z_t model(ops_t o, int frac);
    z_t z;
    z.z0r = w_t'((cre(o.q00r, o.q00i, o.y0r, o.y0i) + cre(o.q10r, o.q10i, o.y1r, o.y1i)) >>> frac);
    z.z0i = w_t'((cim(o.q00r, o.q00i, o.y0r, o.y0i) + cim(o.q10r, o.q10i, o.y1r, o.y1i)) >>> frac);
    z.z1r = w_t'((cre(o.q01r, o.q01i, o.y0r, o.y0i) + cre(o.q11r, o.q11i, o.y1r, o.y1i)) >>> frac);
    z.z1i = w_t'((cim(o.q01r, o.q01i, o.y0r, o.y0i) + cim(o.q11r, o.q11i, o.y1r, o.y1i)) >>> frac);
    return z;
  endfunction

  function automatic ops_t rnd_ops();
    logic [12*W-1:0] b;
    for (int i = 0; i < 12; i++) b[i*W +: W] = W'($urandom());
    return ops_t'(b);
  endfunction

  task automatic apply(input ops_t o);
    bus.y0_re  = o.y0r;  bus.y0_im  = o.y0i;  bus.y1_re  = o.y1r;  bus.y1_im  = o.y1i;
    bus.q00_re = o.q00r; bus.q00_im = o.q00i; bus.q01_re = o.q01r; bus.q01_im = o.q01i;
    bus.q10_re = o.q10r; bus.q10_im = o.q10i; bus.q11_re = o.q11r; bus.q11_im = o.q11i;
  endtask

  // Returns #1 after the accepting edge, i.e. in cycle 1 of the transaction.
  task automatic send(input string tag, input ops_t o, input z_t e);
    int n = 0;
    apply(o);
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'(1));
    @(posedge clk);
    exp_q.push_back(e);
    #1;
    bus.in_valid = 1'b0;
    apply(rnd_ops());
  endtask

  task automatic collect(input string tag, input int hold);
    int cyc = 1;
    z_t e;
    while (!bus.out_valid && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(5));
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s_sb: observed empty queue required one entry", tag);
      return;
    end
    e = exp_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = i[0];
      apply(rnd_ops());
      @(posedge clk); #1;
      check({tag, "_bp_vld"},  64'(bus.out_valid), 64'(1));
      check({tag, "_bp_rdy"},  64'(bus.in_ready),  64'(0));
      check({tag, "_bp_z0r"},  64'(bus.z0_re),     64'(e.z0r));
      check({tag, "_bp_z1i"},  64'(bus.z1_im),     64'(e.z1i));
    end
    bus.in_valid = 1'b0;
    check({tag, "_z0r"}, 64'(bus.z0_re), 64'(e.z0r));
    check({tag, "_z0i"}, 64'(bus.z0_im), 64'(e.z0i));
    check({tag, "_z1r"}, 64'(bus.z1_re), 64'(e.z1r));
    check({tag, "_z1i"}, 64'(bus.z1_im), 64'(e.z1i));
    check({tag, "_busy"}, 64'(busy), 64'(1));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_post_vld"}, 64'(bus.out_valid), 64'(0));
    check({tag, "_post_rdy"}, 64'(bus.in_ready),  64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    ops_t o;
    z_t   e;
    int   n;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; apply('0);
    bus16.in_valid = 1'b0; bus16.out_ready = 1'b0;
    bus16.y0_re = '0; bus16.y0_im = '0; bus16.y1_re = '0; bus16.y1_im = '0;
    bus16.q00_re = '0; bus16.q00_im = '0; bus16.q01_re = '0; bus16.q01_im = '0;
    bus16.q10_re = '0; bus16.q10_im = '0; bus16.q11_re = '0; bus16.q11_im = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  64'(bus.in_ready),  64'(1));
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_busy",      64'(busy),          64'(0));
    check("rst_z",         64'({bus.z0_re, bus.z0_im}), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Identity Q
    o = '{default: 0, q00r: 1, q11r: 1, y0r: 3, y0i: 1, y1r: 2, y1i: -1};
    send("ident", o, '{z0r: 3, z0i: 1, z1r: 2, z1i: -1});
    collect("ident", 0);

    // Conjugation
    o = '{default: 0, q00i: 1, y0r: 2, y1r: 5, y1i: 5};
    send("conj", o, '{z0r: 0, z0i: -2, z1r: 0, z1i: 0});
    collect("conj", 0);

    // Full mix
    o = '{default: 0, q00r: 1, q00i: 2, q10r: 3, q10i: -1, q01r: -2, q11i: 1,
          y0r: 1, y0i: 1, y1r: 2};
    send("mix", o, '{z0r: 9, z0i: 1, z1r: -2, z1i: -4});
    collect("mix", 0);

    // Backpressure for 10 cycles with ignored in_valid pulses
    o = rnd_ops();
    send("bp", o, model(o, 0));
    collect("bp", 10);

    // Wrap of the output slice
    o = '{default: 0, q00r: 134217727, y0r: 134217727};
    send("wrap", o, '{z0r: 1, z0i: 0, z1r: 0, z1i: 0});
    collect("wrap", 0);

    // Random full-range vectors
    for (int t = 0; t < 4; t++) begin
      o = rnd_ops();
      send("rnd", o, model(o, 0));
      collect("rnd", 0);
    end

    // Reset mid-MAC at s=2: z0 has been written one edge earlier
    o = '{default: 0, q00r: 5, q00i: -3, q10r: 2, y0r: 4, y0i: 7, y1r: -6, y1i: 1};
    e = model(o, 0);
    send("rstmac", o, e);
    repeat (2) @(posedge clk);
    #1;
    check("rstmac_z0_pre", 64'(bus.z0_re), 64'(e.z0r));
    rst_n = 1'b0;
    #1;
    check("rstmac_in_ready",  64'(bus.in_ready),  64'(1));
    check("rstmac_out_valid", 64'(bus.out_valid), 64'(0));
    check("rstmac_busy",      64'(busy),          64'(0));
    check("rstmac_z", 64'({bus.z0_re, bus.z0_im}), 64'(0));
    void'(exp_q.pop_back());
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    o = rnd_ops();
    send("after_rst", o, model(o, 0));
    collect("after_rst", 0);

    // FRAC=16 slice on the second instance
    bus16.q00_re = 65536; bus16.y0_re = 7; bus16.y0_im = 3;
    bus16.in_valid = 1'b1;
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    n = 0;
    while (!bus16.out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check("frac16_vld", 64'(bus16.out_valid), 64'(1));
    check("frac16_z0r", 64'(bus16.z0_re), 64'(7));
    check("frac16_z0i", 64'(bus16.z0_im), 64'(3));
    check("frac16_z1",  64'({bus16.z1_re, bus16.z1_im}), 64'(0));
    check("frac16_busy", 64'(busy16), 64'(1));
    bus16.out_ready = 1'b1;
    @(posedge clk); #1;
    bus16.out_ready = 1'b0;
    check("frac16_post_rdy", 64'(bus16.in_ready), 64'(1));

    check("sb_empty", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
